tilemap_scanner: RTL and testbench

TILEMAP_SCANNER -- requirements
Module: tilemap_scanner

---
 rtl/tile_pkg.sv | 41 ++++
 rtl/map_cursor.sv | 60 ++++++
 rtl/tilemap_scanner.sv | 145 ++++++++++++++
 tb/tb_tilemap_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile-map geometry, FSM encoding and draw command layout.
// The tile drawer imports the same geometry so both sides agree on the screen.
package tile_pkg;

  localparam int          MAP_COLS    = 20;
  localparam int          MAP_ROWS    = 15;
  localparam int          TILE_PX     = 8;
  localparam logic [7:0]  SKIP_ID     = 8'hFF;

  // Tile-map RAM address width (MAP_COLS*MAP_ROWS entries fit in 9 bits).
  localparam int          ADDR_W      = 9;

  // Cycles spent in WAIT_ACK before assuming the drawer finished silently.
  localparam int          ACK_TIMEOUT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_ADVANCE
  } state_e;

  // Command handed to the tile drawer.
  typedef struct packed {
    logic [7:0] tile;
    logic [7:0] x;
    logic [7:0] y;
  } draw_cmd_t;

  // Pixel origin of a tile index along one axis, truncated to the 8-bit bus.
  function automatic logic [7:0] tile_origin(input int unsigned idx,
                                             input int unsigned px);
    logic [31:0] prod;
    prod = idx * px;
    return prod[7:0];
  endfunction

endpackage

// File: rtl/map_cursor.sv
// Column/row cursor over the tile map in row-major order.
// clear wins over step; step on the last tile holds the cursor (the owner
// ends the scan there instead of wrapping).
module map_cursor
  import tile_pkg::*;
#(
  parameter int COLS = MAP_COLS,
  parameter int ROWS = MAP_ROWS,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end;

  assign col_end = (col_q == CW'(COLS - 1));
  assign row_end = (row_q == RW'(ROWS - 1));

  // Next cursor position: clear to origin, or step with wrap at end of row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (step && !(col_end && row_end)) begin
      if (!col_end) begin
        col_d = col_q + CW'(1);
      end else begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/tilemap_scanner.sv
// Walks the tile map once per start request, reads each tile id from the
// map RAM and hands every non-transparent tile to the tile drawer with its
// pixel origin, waiting for the drawer's busy handshake between tiles.
module tilemap_scanner #(
  parameter int         MAP_COLS = tile_pkg::MAP_COLS,
  parameter int         MAP_ROWS = tile_pkg::MAP_ROWS,
  parameter int         TILE_PX  = tile_pkg::TILE_PX,
  parameter logic [7:0] SKIP_ID  = tile_pkg::SKIP_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [tile_pkg::ADDR_W-1:0] map_addr,
  input  logic [7:0]                 map_data,
  output logic [7:0]                 tile_address,
  output logic [7:0]                 x_pos,
  output logic [7:0]                 y_pos,
  output logic                       draw,
  input  logic                       drawer_active,
  output logic                       busy,
  output logic                       done
);
  import tile_pkg::*;

  localparam int CW = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int RW = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   map_addr_q, map_addr_d;
  draw_cmd_t           cmd_q, cmd_d;
  logic                draw_q, draw_d;
  logic                done_q, done_d;
  logic [2:0]          ack_cnt_q, ack_cnt_d;

  logic                cur_clear, cur_step;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                last;

  map_cursor #(
    .COLS (MAP_COLS),
    .ROWS (MAP_ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .clear (cur_clear),
    .step  (cur_step),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  // Next-state and output-register logic for the scan sequence.
  // The map address is loaded on the edge into FETCH so the RAM's one-cycle
  // read is on map_data throughout WAIT_DATA. draw is registered from ISSUE,
  // so drawer_active never reaches it combinationally.
  always_comb begin
    state_d    = state_q;
    map_addr_d = map_addr_q;
    cmd_d      = cmd_q;
    draw_d     = 1'b0;
    done_d     = 1'b0;
    ack_cnt_d  = '0;
    cur_clear  = 1'b0;
    cur_step   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start landing on the done pulse belongs to the finished scan.
        if (start && !done_q) begin
          cur_clear  = 1'b1;
          map_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        cmd_d.tile = map_data;
        cmd_d.x    = tile_origin(32'(col), TILE_PX);
        cmd_d.y    = tile_origin(32'(row), TILE_PX);
        state_d    = (map_data == SKIP_ID) ? S_ADVANCE : S_ISSUE;
      end
      S_ISSUE: begin
        draw_d  = 1'b1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (drawer_active) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == 3'(ACK_TIMEOUT - 1)) begin
          // Drawer finished without ever showing active.
          state_d = S_ADVANCE;
        end else begin
          ack_cnt_d = ack_cnt_q + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!drawer_active) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Row-major order means the next address is always +1.
          cur_step   = 1'b1;
          map_addr_d = map_addr_q + ADDR_W'(1);
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      map_addr_q <= '0;
      cmd_q      <= '0;
      draw_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      map_addr_q <= map_addr_d;
      cmd_q      <= cmd_d;
      draw_q     <= draw_d;
      done_q     <= done_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  assign map_addr     = map_addr_q;
  assign tile_address = cmd_q.tile;
  assign x_pos        = cmd_q.x;
  assign y_pos        = cmd_q.y;
  assign draw         = draw_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_tilemap_scanner.sv
// Bench for tilemap_scanner: synchronous map RAM model, tile drawer model,
// and a scoreboard of expected draw commands in row-major order.
module tb_tilemap_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] map_addr;
  logic [7:0] map_data = 8'h00;
  logic [7:0] tile_address, x_pos, y_pos;
  logic       draw;
  logic       drawer_active = 1'b0;
  logic       busy, done;

  always #5 clk = ~clk;

  tilemap_scanner dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .map_addr      (map_addr),
    .map_data      (map_data),
    .tile_address  (tile_address),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .draw          (draw),
    .drawer_active (drawer_active),
    .busy          (busy),
    .done          (done)
  );

  // Map RAM: data for an address shows up one cycle later.
  logic [7:0] mem [512];
  always @(posedge clk) map_data <= mem[map_addr];

  // Drawer: active one cycle after draw, held for 5 cycles; or never active.
  bit never_ack = 1'b0;
  int act_cnt   = 0;
  always @(posedge clk) begin
    if (never_ack) begin
      drawer_active <= 1'b0;
      act_cnt       <= 0;
    end else if (draw) begin
      drawer_active <= 1'b1;
      act_cnt       <= 5;
    end else if (act_cnt > 0) begin
      act_cnt       <= act_cnt - 1;
      drawer_active <= (act_cnt > 1);
    end
  end

  int          n_chk = 0, n_err = 0;
  int          n_draw = 0, n_done = 0;
  logic [7:0]  last_x = 8'h00, last_y = 8'h00;
  logic [23:0] exp_q [$];
  logic [23:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every draw is matched against the scoreboard head.
  always @(negedge clk) begin
    if (draw) begin
      n_draw++;
      last_x = x_pos;
      last_y = y_pos;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("draw_cmd", {8'h00, tile_address, x_pos, y_pos}, {8'h00, mon_exp});
      end
      chk("draw_while_active", {31'd0, drawer_active}, 32'd0);
    end
    if (done) n_done++;
  end

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 512; i++) mem[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 512; i++) mem[i] = 8'(i % 200);
  endtask

  task automatic push_scan();
    logic [7:0] t;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) begin
        t = mem[r * 20 + c];
        if (t != 8'hFF) exp_q.push_back({t, 8'(c * 8), 8'(r * 8)});
      end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < bound);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd, bn, lat, k, n, gap_bad, to;
    reset = 1'b1;
    start = 1'b0;
    fill_const(8'd3);
    repeat (3) @(negedge clk);
    chk("rst_map_addr", {23'd0, map_addr}, 32'd0);
    chk("rst_tile",     {24'd0, tile_address}, 32'd0);
    chk("rst_x",        {24'd0, x_pos}, 32'd0);
    chk("rst_y",        {24'd0, y_pos}, 32'd0);
    chk("rst_draw",     {31'd0, draw}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_draw", {31'd0, draw}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    // A: full map of id 3, handshaking drawer.
    bd = n_draw; bn = n_done;
    push_scan();
    pulse_start();
    lat = 1;
    while (!draw && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("A_latency", lat, 32'd4);
    wait_done(6000);
    repeat (2) @(negedge clk);
    chk("A_draws",   n_draw - bd, 32'd300);
    chk("A_done",    n_done - bn, 32'd1);
    chk("A_last_x",  {24'd0, last_x}, 32'd152);
    chk("A_last_y",  {24'd0, last_y}, 32'd112);
    chk("A_busy",    {31'd0, busy}, 32'd0);
    chk("A_sb_left", exp_q.size(), 32'd0);

    // B: tile 0 transparent, rest id 7.
    fill_const(8'd7);
    mem[0] = 8'hFF;
    bd = n_draw; bn = n_done;
    push_scan();
    pulse_start();
    n = 0;
    while (!draw && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("B_first_tile", {24'd0, tile_address}, 32'd7);
    chk("B_first_x",    {24'd0, x_pos}, 32'd8);
    chk("B_first_y",    {24'd0, y_pos}, 32'd0);
    wait_done(6000);
    repeat (2) @(negedge clk);
    chk("B_draws", n_draw - bd, 32'd299);
    chk("B_done",  n_done - bn, 32'd1);

    // C: drawer never active -> WAIT_ACK times out, 8 cycles per tile.
    never_ack = 1'b1;
    fill_const(8'd3);
    bd = n_draw; bn = n_done;
    push_scan();
    pulse_start();
    gap_bad = 0; to = 0;
    for (int t = 0; t < 300; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!draw && n < 40);
      if (!draw) to++;
      else if (t > 0 && n != 8) gap_bad++;
    end
    chk("C_draw_timeouts", to, 32'd0);
    chk("C_gap_not_8",     gap_bad, 32'd0);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("C_draws", n_draw - bd, 32'd300);
    chk("C_done",  n_done - bn, 32'd1);

    // D: reset while in WAIT_DONE at tile (5,2), then rescan.
    never_ack = 1'b0;
    fill_ramp();
    push_scan();
    pulse_start();
    k = 0; n = 0;
    while (k < 46 && n < 2000) begin
      @(negedge clk);
      n++;
      if (draw) k++;
    end
    chk("D_tile45", {8'h00, tile_address, x_pos, y_pos}, {8'h00, 8'd45, 8'd40, 8'd16});
    repeat (3) @(negedge clk);
    chk("D_active_before", {31'd0, drawer_active}, 32'd1);
    chk("D_busy_before",   {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("D_rst_busy",     {31'd0, busy}, 32'd0);
    chk("D_rst_draw",     {31'd0, draw}, 32'd0);
    chk("D_rst_done",     {31'd0, done}, 32'd0);
    chk("D_rst_map_addr", {23'd0, map_addr}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    bd = n_draw; bn = n_done;
    push_scan();
    pulse_start();
    chk("D_rescan_addr", {23'd0, map_addr}, 32'd0);
    wait_done(6000);
    repeat (2) @(negedge clk);
    chk("D_draws",   n_draw - bd, 32'd300);
    chk("D_done",    n_done - bn, 32'd1);
    chk("D_sb_left", exp_q.size(), 32'd0);

    // E: start while busy and on the done cycle are both ignored.
    never_ack = 1'b1;
    bd = n_draw; bn = n_done;
    push_scan();
    pulse_start();
    repeat (100) @(negedge clk);
    chk("E_busy_mid", {31'd0, busy}, 32'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(4000);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("E_no_restart", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    chk("E_draws",   n_draw - bd, 32'd300);
    chk("E_done",    n_done - bn, 32'd1);
    chk("E_busy",    {31'd0, busy}, 32'd0);
    chk("E_sb_left", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
